// File: rtl/atomic_alu_pkg.sv
// Shared types and constants for the atomic ALU engine: opcodes, FSM states, flag bit positions.
package atomic_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_OR   = 3'b010,
    OP_AND  = 3'b011,
    OP_XOR  = 3'b100,
    OP_FADD = 3'b101,
    OP_SWAP = 3'b110,
    OP_CAS  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB2,
    ST_RESP
  } state_e;

  // Bit positions inside the 4-bit {Z,N,C,V} flag word.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic int cmd_width(input int aw);
    return OP_W + 3 * aw;
  endfunction

endpackage

// File: rtl/atomic_alu_if.sv
// Command/response handshake bundle between a command source (master) and the ALU core (slave).
interface atomic_alu_if
  import atomic_alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AW     = 3
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [cmd_width(AW)-1:0]   cmd;
  logic                       res_valid;
  logic                       res_ready;
  logic [DATA_W-1:0]          res_data;
  logic                       res_ok;
  logic [3:0]                 res_flags;

  modport master (
    output cmd_valid, cmd, res_ready,
    input  cmd_ready, res_valid, res_data, res_ok, res_flags
  );

  modport slave (
    input  cmd_valid, cmd, res_ready,
    output cmd_ready, res_valid, res_data, res_ok, res_flags
  );
endinterface

// File: rtl/atomic_alu_regfile.sv
// NREGS x DATA_W register file: three combinational read ports, a debug read port, one synchronous write.
module atomic_alu_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra_addr_i,
  input  logic [AW-1:0]     rb_addr_i,
  input  logic [AW-1:0]     rc_addr_i,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  output logic [DATA_W-1:0] rc_data_o,
  output logic [DATA_W-1:0] dbg_data_o,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // NOTE: every entry is reset (to its own index), so this array maps to flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= DATA_W'(i);
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o  = regs_q[ra_addr_i];
  assign rb_data_o  = regs_q[rb_addr_i];
  assign rc_data_o  = regs_q[rc_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/atomic_alu_core.sv
// Atomic ALU engine: command FSM, ALU and result registers around atomic_alu_regfile.
// Define ATOMIC_ALU_FLAGS_EN to produce {Z,N,C,V} flags; otherwise res_flags is tied to zero.
module atomic_alu_core
  import atomic_alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  atomic_alu_if.slave       bus,
  output logic              busy,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef struct packed {
    op_e           op;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
  } cmd_t;

  state_e            state_q;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] old_a_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_ok_q;
  logic [3:0]        res_flags_q;
  logic              res_valid_q;
  logic              cmd_ready_q;

  logic [DATA_W-1:0] ra, rb, rc, sum, diff;
  logic [DATA_W-1:0] alu_res, wr_val, wdata;
  logic [AW-1:0]     waddr;
  logic              wr_to_a, wr_en_op, ok_d, we;
  logic [3:0]        flags_d;

  atomic_alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_addr_i  (cmd_q.a),
    .rb_addr_i  (cmd_q.b),
    .rc_addr_i  (cmd_q.c),
    .dbg_addr_i (dbg_addr),
    .ra_data_o  (ra),
    .rb_data_o  (rb),
    .rc_data_o  (rc),
    .dbg_data_o (dbg_data),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata)
  );

  assign sum  = ra + rb;
  assign diff = ra - rb;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    alu_res  = ra;
    wr_val   = '0;
    wr_to_a  = 1'b0;
    wr_en_op = 1'b1;
    ok_d     = 1'b1;
    case (cmd_q.op)
      OP_ADD:  begin alu_res = sum;     wr_val = sum;     end
      OP_SUB:  begin alu_res = diff;    wr_val = diff;    end
      OP_OR:   begin alu_res = ra | rb; wr_val = ra | rb; end
      OP_AND:  begin alu_res = ra & rb; wr_val = ra & rb; end
      OP_XOR:  begin alu_res = ra ^ rb; wr_val = ra ^ rb; end
      OP_FADD: begin wr_val = sum; wr_to_a = 1'b1; end
      OP_SWAP: begin wr_val = rb;  wr_to_a = 1'b1; end
      OP_CAS:  begin
        wr_val   = rc;
        wr_to_a  = 1'b1;
        ok_d     = (ra == rb);
        wr_en_op = (ra == rb);
      end
      default: ;
    endcase
  end

  // The second SWAP write uses the old R[a] captured in EXEC, so a==b rewrites the same value.
  always_comb begin
    if (state_q == ST_WB2) begin
      we    = 1'b1;
      waddr = cmd_q.b;
      wdata = old_a_q;
    end else begin
      we    = (state_q == ST_EXEC) && wr_en_op;
      waddr = wr_to_a ? cmd_q.a : cmd_q.c;
      wdata = wr_val;
    end
  end

`ifdef ATOMIC_ALU_FLAGS_EN
  // Unsigned compares give carry (sum wrapped below ra) and borrow without widened adders.
  always_comb begin
    flags_d = '0;
    case (cmd_q.op)
      OP_ADD, OP_FADD: begin
        flags_d[FLAG_Z] = (sum == '0);
        flags_d[FLAG_N] = sum[DATA_W-1];
        flags_d[FLAG_C] = (sum < ra);
        flags_d[FLAG_V] = (ra[DATA_W-1] == rb[DATA_W-1]) && (sum[DATA_W-1] != ra[DATA_W-1]);
      end
      OP_SUB: begin
        flags_d[FLAG_Z] = (diff == '0);
        flags_d[FLAG_N] = diff[DATA_W-1];
        flags_d[FLAG_C] = (ra < rb);
        flags_d[FLAG_V] = (ra[DATA_W-1] != rb[DATA_W-1]) && (diff[DATA_W-1] != ra[DATA_W-1]);
      end
      default: begin
        flags_d[FLAG_Z] = (alu_res == '0);
        flags_d[FLAG_N] = alu_res[DATA_W-1];
      end
    endcase
  end
`else
  assign flags_d = 4'b0000;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '{op: OP_ADD, default: '0};
      old_a_q     <= '0;
      res_data_q  <= '0;
      res_ok_q    <= 1'b0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.cmd_valid) begin
          cmd_q       <= cmd_t'(bus.cmd);
          cmd_ready_q <= 1'b0;
          state_q     <= ST_EXEC;
        end
        ST_EXEC: begin
          old_a_q     <= ra;
          res_data_q  <= alu_res;
          res_ok_q    <= ok_d;
          res_flags_q <= flags_d;
          if (cmd_q.op == OP_SWAP) begin
            state_q <= ST_WB2;
          end else begin
            res_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_WB2: begin
          res_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ok    = res_ok_q;
  assign bus.res_flags = res_flags_q;
  assign busy          = ~cmd_ready_q;

endmodule

// File: tb/tb_atomic_alu_core.sv
// Directed bench for atomic_alu_core (DATA_W=8, NREGS=8): vector table plus stall/SWAP/reset sequences.
module tb_atomic_alu_core;

`ifdef ATOMIC_ALU_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int total = 0;
  int bad   = 0;

  atomic_alu_if #(.DATA_W(8), .AW(3)) bus ();

  atomic_alu_core #(.DATA_W(8), .NREGS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [2:0] a, b, c;
    logic [7:0] res;
    logic       ok;
    logic [3:0] flg;
    logic [2:0] chk_addr;
    logic [7:0] chk_val;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c);
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_before_issue", 32'(bus.cmd_ready), 32'd1);
    bus.cmd       = {op, a, b, c};
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 12'hFFF;
  endtask

  // Returns the number of edges from (and including) the accept edge until res_valid is seen.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.res_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    int lat;
    bus.cmd_valid = 1'b0;
    bus.cmd       = '0;
    bus.res_ready = 1'b0;

    vecs[0]  = '{3'd0, 3'd1, 3'd2, 3'd7, 8'h03, 1'b1, 4'b0000, 3'd7, 8'h03}; // ADD
    vecs[1]  = '{3'd1, 3'd3, 3'd4, 3'd0, 8'hFF, 1'b1, 4'b0110, 3'd0, 8'hFF}; // SUB borrow
    vecs[2]  = '{3'd7, 3'd1, 3'd1, 3'd3, 8'h01, 1'b1, 4'b0000, 3'd1, 8'h03}; // CAS hit
    vecs[3]  = '{3'd7, 3'd2, 3'd3, 3'd4, 8'h02, 1'b0, 4'b0000, 3'd2, 8'h02}; // CAS miss
    vecs[4]  = '{3'd3, 3'd7, 3'd6, 3'd4, 8'h02, 1'b1, 4'b0000, 3'd4, 8'h02}; // AND
    vecs[5]  = '{3'd4, 3'd0, 3'd5, 3'd3, 8'hFA, 1'b1, 4'b0100, 3'd3, 8'hFA}; // XOR
    vecs[6]  = '{3'd2, 3'd2, 3'd1, 3'd2, 8'h03, 1'b1, 4'b0000, 3'd2, 8'h03}; // OR
    vecs[7]  = '{3'd5, 3'd0, 3'd7, 3'd0, 8'hFF, 1'b1, 4'b0010, 3'd0, 8'h02}; // FADD carry
    vecs[8]  = '{3'd0, 3'd3, 3'd3, 3'd5, 8'hF4, 1'b1, 4'b0110, 3'd5, 8'hF4}; // ADD neg
    vecs[9]  = '{3'd1, 3'd4, 3'd3, 3'd6, 8'h08, 1'b1, 4'b0010, 3'd6, 8'h08}; // SUB borrow
    vecs[10] = '{3'd6, 3'd7, 3'd7, 3'd0, 8'h03, 1'b1, 4'b0000, 3'd7, 8'h03}; // SWAP a==b
    vecs[11] = '{3'd1, 3'd2, 3'd2, 3'd1, 8'h00, 1'b1, 4'b1000, 3'd1, 8'h00}; // SUB zero

    do_reset();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_ok", 32'(bus.res_ok), 32'd0);
    check("rst_res_flags", 32'(bus.res_flags), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d);
      check($sformatf("rst_reg%0d", i), 32'(d), 32'(i));
    end

    // SWAP 5,6: one extra cycle for the second write.
    issue(3'd6, 3'd5, 3'd6, 3'd0);
    check("swap_busy", 32'(busy), 32'd1);
    wait_resp(lat);
    check("swap_latency", 32'(lat), 32'd3);
    check("swap_res", 32'(bus.res_data), 32'h05);
    check("swap_ok", 32'(bus.res_ok), 32'd1);
    consume();
    rd(3'd5, d); check("swap_r5", 32'(d), 32'h06);
    rd(3'd6, d); check("swap_r6", 32'(d), 32'h05);

    // Reset while in WB2: the half-done SWAP must be discarded along with everything else.
    do_reset();
    issue(3'd6, 3'd5, 3'd6, 3'd0);
    @(posedge clk); #1;
    rd(3'd5, d); check("wb2_r5_written", 32'(d), 32'h06);
    rst_n = 1'b0;
    #1;
    check("wb2rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("wb2rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rd(3'd5, d); check("wb2rst_r5", 32'(d), 32'h05);
    rd(3'd6, d); check("wb2rst_r6", 32'(d), 32'h06);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("wb2rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("wb2rel_res_valid", 32'(bus.res_valid), 32'd0);

    // Response stall: outputs hold, cmd_ready stays low, a pulsed command is ignored.
    issue(3'd0, 3'd1, 3'd2, 3'd7);
    wait_resp(lat);
    check("stall_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.cmd = {3'd4, 3'd1, 3'd2, 3'd5};
        bus.cmd_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check($sformatf("stall%0d_valid", i), 32'(bus.res_valid), 32'd1);
      check($sformatf("stall%0d_data", i), 32'(bus.res_data), 32'h03);
      check($sformatf("stall%0d_ready", i), 32'(bus.cmd_ready), 32'd0);
    end
    consume();
    check("post_stall_ready", 32'(bus.cmd_ready), 32'd1);
    check("post_stall_valid", 32'(bus.res_valid), 32'd0);
    repeat (3) @(posedge clk);
    rd(3'd5, d); check("stall_ignored_r5", 32'(d), 32'h05);
    rd(3'd7, d); check("stall_add_r7", 32'(d), 32'h03);

    // Table run from a clean register file; vectors chain through register state.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
      wait_resp(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), (vecs[i].op == 3'd6) ? 32'd3 : 32'd2);
      check($sformatf("v%0d_res", i), 32'(bus.res_data), 32'(vecs[i].res));
      check($sformatf("v%0d_ok", i), 32'(bus.res_ok), 32'(vecs[i].ok));
      check($sformatf("v%0d_flags", i), 32'(bus.res_flags), FLAGS_ON ? 32'(vecs[i].flg) : 32'd0);
      consume();
      rd(vecs[i].chk_addr, d);
      check($sformatf("v%0d_reg", i), 32'(d), 32'(vecs[i].chk_val));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
